// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: sample width, Q8.8 unity and complex sample type.
// Used by the butterflies, the commutators and the twiddle ROM.
// No logic; types and constants only.
package fft_pkg;

    localparam int DATA_W = 16;

    localparam logic signed [DATA_W-1:0] ONE = 16'sd256;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/delay_line.sv
// Valid-gated shift register of DEPTH stages; q is d from DEPTH enables earlier.
// Latency: DEPTH enabled cycles; no combinational path from d to q.
// Backpressure: none, holds contents while en is low.
module delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/r2mdc_commutator.sv
// R2MDC delay commutator: pairs samples DELAY apart from the x/y streams for the next butterfly.
// Latency: one clock after the in_valid edge that completes a pair; first DELAY inputs emit nothing.
// Backpressure: none; all state advances only on in_valid, gaps stall without data loss.
module r2mdc_commutator #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int DELAY  = 4,
    parameter int LOG2D  = (DELAY > 1) ? $clog2(DELAY) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in0_re,
    input  logic [DATA_W-1:0] in0_im,
    input  logic [DATA_W-1:0] in1_re,
    input  logic [DATA_W-1:0] in1_im,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a_re,
    output logic [DATA_W-1:0] out_a_im,
    output logic [DATA_W-1:0] out_b_re,
    output logic [DATA_W-1:0] out_b_im,
    output logic              out_src,
    output logic [LOG2D-1:0]  tw_idx
);

    localparam int CW = LOG2D + 1;
    localparam int SW = 2 * DATA_W;

    logic [CW-1:0]    cnt;
    logic             sel;
    logic             primed;
    logic [SW-1:0]    x_dat, y_dat, y_d, m0, m1, a_d;
    logic [LOG2D-1:0] tw_next;
    logic [SW-1:0]    a_q, b_q;

    assign x_dat = {in0_re, in0_im};
    assign y_dat = {in1_re, in1_im};

    // Second half of each 2D-sample frame routes delayed y to the A path.
    assign sel = (cnt >= CW'(DELAY));
    assign m0  = sel ? y_d : x_dat;
    assign m1  = sel ? x_dat : y_d;

    generate
        if (DELAY == 1) begin : g_tw_one
            assign tw_next = '0;
        end else begin : g_tw_cnt
            assign tw_next = cnt[LOG2D-1:0];
        end
    endgenerate

    delay_line #(.DEPTH(DELAY), .W(SW)) ydl (
        .clk (clk),
        .rst (rst),
        .en  (in_valid),
        .d   (y_dat),
        .q   (y_d)
    );

    delay_line #(.DEPTH(DELAY), .W(SW)) adl (
        .clk (clk),
        .rst (rst),
        .en  (in_valid),
        .d   (m0),
        .q   (a_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (in_valid) begin
            if (cnt == CW'(2 * DELAY - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CW'(DELAY - 1)) begin
                primed <= 1'b1;
            end
        end
    end

    // Data registers load on every valid input; out_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            out_src   <= 1'b0;
            tw_idx    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid & primed;
            if (in_valid) begin
                a_q     <= a_d;
                b_q     <= m1;
                out_src <= ~sel;
                tw_idx  <= tw_next;
            end
        end
    end

    assign out_a_re = a_q[SW-1:DATA_W];
    assign out_a_im = a_q[DATA_W-1:0];
    assign out_b_re = b_q[SW-1:DATA_W];
    assign out_b_im = b_q[DATA_W-1:0];

endmodule

// File: tb/tb_r2mdc_commutator.sv
// Directed bench for r2mdc_commutator at DELAY = 2, 4 and 1, all instances on one shared stimulus.
module tb_r2mdc_commutator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in0_re = '0, in0_im = '0, in1_re = '0, in1_im = '0;

    logic        ov2, src2, ov4, src4, ov1, src1;
    logic [15:0] a2re, a2im, b2re, b2im;
    logic [15:0] a4re, a4im, b4re, b4im;
    logic [15:0] a1re, a1im, b1re, b1im;
    logic [0:0]  tw2, tw1;
    logic [1:0]  tw4;

    int n_checks = 0;
    int n_fail   = 0;

    int xs [10] = '{1, 2, 3, 4, 21, 22, 23, 24, 0, 0};
    int ys [10] = '{11, 12, 13, 14, 31, 32, 33, 34, 0, 0};
    int ea [10] = '{0, 0, 1, 2, 11, 12, 21, 22, 31, 32};
    int es [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};

    wire [66:0] got2 = {ov2, a2re, a2im, b2re, b2im, src2, tw2};
    wire [67:0] got4 = {ov4, a4re, a4im, b4re, b4im, src4, tw4};
    wire [66:0] got1 = {ov1, a1re, a1im, b1re, b1im, src1, tw1};

    r2mdc_commutator #(.DATA_W(16), .DELAY(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
        .out_valid(ov2), .out_a_re(a2re), .out_a_im(a2im),
        .out_b_re(b2re), .out_b_im(b2im), .out_src(src2), .tw_idx(tw2)
    );

    r2mdc_commutator #(.DATA_W(16), .DELAY(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
        .out_valid(ov4), .out_a_re(a4re), .out_a_im(a4im),
        .out_b_re(b4re), .out_b_im(b4im), .out_src(src4), .tw_idx(tw4)
    );

    r2mdc_commutator #(.DATA_W(16), .DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
        .out_valid(ov1), .out_a_re(a1re), .out_a_im(a1im),
        .out_b_re(b1re), .out_b_im(b1im), .out_src(src1), .tw_idx(tw1)
    );

    always #5 clk = ~clk;

    task automatic step_raw(input logic v, input logic [15:0] xr, input logic [15:0] xi,
                            input logic [15:0] yr, input logic [15:0] yi);
        in_valid = v;
        in0_re = xr; in0_im = xi; in1_re = yr; in1_im = yi;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input int x, input int y);
        step_raw(v, 16'(x), 16'(-x), 16'(y), 16'(-y));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (got2 !== '0) begin n_fail++; $display("FAIL reset_d2: got %h expected 0", got2); end
        n_checks++;
        if (got4 !== '0) begin n_fail++; $display("FAIL reset_d4: got %h expected 0", got4); end
        n_checks++;
        if (got1 !== '0) begin n_fail++; $display("FAIL reset_d1: got %h expected 0", got1); end
    endtask

    task automatic test_continuous();
        logic [66:0] exp;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            step(1'b1, xs[n], ys[n]);
            n_checks++;
            if (n < 2) begin
                if (ov2 !== 1'b0) begin n_fail++; $display("FAIL cont_prime n=%0d: out_valid %b expected 0", n, ov2); end
            end else begin
                exp = {1'b1, 16'(ea[n]), 16'(-ea[n]), 16'(ea[n] + 2), 16'(-(ea[n] + 2)), es[n][0], 1'(n % 2)};
                if (got2 !== exp) begin n_fail++; $display("FAIL cont_pair n=%0d: got %h expected %h", n, got2, exp); end
            end
        end
    endtask

    task automatic test_gap();
        logic [66:0] exp;
        int j = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i >= 3 && i < 6) begin
                step(1'b0, 0, 0);
                exp = {1'b0, 16'(1), 16'(-1), 16'(3), 16'(-3), 1'b0, 1'b0};
                n_checks++;
                if (got2 !== exp) begin n_fail++; $display("FAIL gap_hold i=%0d: got %h expected %h", i, got2, exp); end
            end else begin
                step(1'b1, xs[j], ys[j]);
                if (j >= 2) begin
                    exp = {1'b1, 16'(ea[j]), 16'(-ea[j]), 16'(ea[j] + 2), 16'(-(ea[j] + 2)), es[j][0], 1'(j % 2)};
                    n_checks++;
                    if (got2 !== exp) begin n_fail++; $display("FAIL gap_pair j=%0d: got %h expected %h", j, got2, exp); end
                end
                j++;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [66:0] exp;
        do_reset();
        for (int n = 0; n < 5; n++) step(1'b1, xs[n], ys[n]);
        do_reset();
        n_checks++;
        if (got2 !== '0) begin n_fail++; $display("FAIL midrst_clear: got %h expected 0", got2); end
        for (int n = 0; n < 3; n++) begin
            step(1'b1, xs[n], ys[n]);
            n_checks++;
            if (n < 2) begin
                if (ov2 !== 1'b0) begin n_fail++; $display("FAIL midrst_prime n=%0d: out_valid %b expected 0", n, ov2); end
            end else begin
                exp = {1'b1, 16'(1), 16'(-1), 16'(3), 16'(-3), 1'b0, 1'b0};
                if (got2 !== exp) begin n_fail++; $display("FAIL midrst_first: got %h expected %h", got2, exp); end
            end
        end
    endtask

    task automatic test_rst_priority();
        logic [66:0] exp;
        do_reset();
        for (int n = 0; n < 3; n++) step(1'b1, xs[n], ys[n]);
        rst = 1'b1;
        step(1'b1, 99, 98);
        rst = 1'b0;
        n_checks++;
        if (got2 !== '0) begin n_fail++; $display("FAIL prio_out: got %h expected 0", got2); end
        n_checks++;
        if ({dut2.cnt, dut2.primed} !== 3'b000) begin
            n_fail++; $display("FAIL prio_state: cnt/primed %b expected 000", {dut2.cnt, dut2.primed});
        end
        for (int n = 0; n < 3; n++) begin
            step(1'b1, xs[n], ys[n]);
            n_checks++;
            if (n < 2) begin
                if (ov2 !== 1'b0) begin n_fail++; $display("FAIL prio_prime n=%0d: out_valid %b expected 0", n, ov2); end
            end else begin
                exp = {1'b1, 16'(1), 16'(-1), 16'(3), 16'(-3), 1'b0, 1'b0};
                if (got2 !== exp) begin n_fail++; $display("FAIL prio_first: got %h expected %h", got2, exp); end
            end
        end
    endtask

    task automatic test_fullscale();
        logic [66:0] exp;
        do_reset();
        step_raw(1'b1, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
        step_raw(1'b1, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
        step_raw(1'b1, 16'h0100, 16'hFF00, 16'h0000, 16'h0000);
        exp = {1'b1, 16'h7FFF, 16'h8000, 16'h0100, 16'hFF00, 1'b0, 1'b0};
        n_checks++;
        if (got2 !== exp) begin n_fail++; $display("FAIL fullscale_0: got %h expected %h", got2, exp); end
        step_raw(1'b1, 16'hFF00, 16'h0100, 16'h0000, 16'h0000);
        exp = {1'b1, 16'h8000, 16'h7FFF, 16'hFF00, 16'h0100, 1'b0, 1'b1};
        n_checks++;
        if (got2 !== exp) begin n_fail++; $display("FAIL fullscale_1: got %h expected %h", got2, exp); end
    endtask

    task automatic test_ramp_d4();
        logic [67:0] exp;
        int c, k, a;
        logic s;
        do_reset();
        for (int n = 0; n < 28; n++) begin
            step(1'b1, (n < 24) ? n : 0, (n < 24) ? 1000 + n : 0);
            n_checks++;
            if (n < 4) begin
                if (ov4 !== 1'b0) begin n_fail++; $display("FAIL d4_prime n=%0d: out_valid %b expected 0", n, ov4); end
            end else begin
                c = n % 8;
                if (c >= 4) begin k = c - 4; a = n - c + k;            s = 1'b0; end
                else        begin k = c;     a = 1000 + n - c - 8 + k; s = 1'b1; end
                exp = {1'b1, 16'(a), 16'(-a), 16'(a + 4), 16'(-(a + 4)), s, 2'(k)};
                if (got4 !== exp) begin n_fail++; $display("FAIL d4_pair n=%0d: got %h expected %h", n, got4, exp); end
            end
        end
    endtask

    task automatic test_ramp_d1();
        logic [66:0] exp;
        int a;
        logic s;
        do_reset();
        for (int n = 0; n < 7; n++) begin
            step(1'b1, (n < 6) ? n : 0, (n < 6) ? 1000 + n : 0);
            n_checks++;
            if (n < 1) begin
                if (ov1 !== 1'b0) begin n_fail++; $display("FAIL d1_prime: out_valid %b expected 0", ov1); end
            end else begin
                if (n % 2 == 1) begin a = n - 1;        s = 1'b0; end
                else            begin a = 1000 + n - 2; s = 1'b1; end
                exp = {1'b1, 16'(a), 16'(-a), 16'(a + 1), 16'(-(a + 1)), s, 1'b0};
                if (got1 !== exp) begin n_fail++; $display("FAIL d1_pair n=%0d: got %h expected %h", n, got1, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gap();
        test_mid_reset();
        test_rst_priority();
        test_fullscale();
        test_ramp_d4();
        test_ramp_d1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/r2mdc_commutator.md
Name: r2mdc_commutator

Overview:
Delay-commutator stage of the R2MDC FFT pipeline. It sits between two bf_radix2 stages and consumes the Y0/Y1 streams of the previous butterfly. It produces aligned (A, B) operand pairs spaced DELAY samples apart for the next butterfly, plus a twiddle index. Data is 16-bit signed Q8.8 (256 = 1.0), with independent re/im lanes; the block does no arithmetic on the data.

Parameters:
DATA_W, 16, width of each re/im sample (signed Q8.8)
DELAY, 4, commutator distance D; power of 2, >= 1
LOG2D, $clog2(DELAY) (min 1), width of the twiddle index

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  one sample per stream this cycle
in0_re, in0_im  in  DATA_W  upper stream x (upstream Y0)
in1_re, in1_im  in  DATA_W  lower stream y (upstream Y1)
out_valid  out  1  out_a/out_b hold a genuine pair
out_a_re, out_a_im  out  DATA_W  butterfly A operand
out_b_re, out_b_im  out  DATA_W  butterfly B operand
out_src  out  1  0 = pair taken from x, 1 = pair taken from y
tw_idx  out  LOG2D  pair index k within its group (0..D-1), used as the twiddle ROM address

Behaviour:
- Every state element advances only on in_valid. Gaps in in_valid stall the block with no loss of data.
- cnt: sample counter mod 2D, incremented per valid input. sel = (cnt >= D).
- ydl: D-deep valid-gated delay of y. y_d is the value of y from D valid samples earlier.
- Mux: m0 = sel ? y_d : x, and m1 = sel ? x : y_d.
- adl: D-deep valid-gated delay of m0.
- Pair formed at each valid input: A = adl output (m0 from D samples earlier), B = m1.
- Resulting order for one frame of 2D input samples:
  - during inputs n = D..2D-1: x pairs (x_k, x_{k+D});
  - during inputs n = 0..D-1 of the following frame: y pairs (y_k, y_{k+D}) from the previous frame.
- Output register: on an in_valid cycle, out_a/out_b/out_src/tw_idx are loaded with the pair, out_src = ~sel, and tw_idx = cnt[LOG2D-1:0]. Latency is one clock after the in_valid edge that completes the pair.
- out_valid is registered and equals in_valid & primed. It is 0 on cycles without in_valid; out_* data holds its last value.
- primed: set once D valid inputs have been accepted since reset. It stays set until reset. The first D inputs after reset produce no output.
- Drain: the y pairs of the final frame are emitted only when D further valid inputs arrive. Upstream pads with zeros.
- Reset (sync, active-high) clears cnt, primed, both delay lines, all outputs, out_valid and tw_idx to 0. Reset asserted mid-stream discards all data in flight. The first valid input after reset is treated as n = 0.
- rst has priority over in_valid in the same cycle.
- cnt wraps from 2D-1 to 0 with no bubble. Back-to-back frames stream at one pair per valid input.
- DELAY = 1: delays are single registers, sel toggles every valid input, and tw_idx is constant 0.

Decomposition:
- Shared package fft_pkg: DATA_W, the Q8.8 constant ONE = 16'sd256, and a complex-sample struct {re, im}. It is shared with bf_radix2 and the twiddle ROM.
- Sub-module delay_line (params DEPTH, W; ports clk, rst, en, d, q): a valid-gated shift register cleared on rst. It is instantiated twice (ydl, adl), each on a 2*DATA_W bus carrying re and im.

Test Plan:
- D=2, continuous in_valid. Frame 1: x.re = 1,2,3,4 and y.re = 11,12,13,14 (im = -re). Frame 2: x = 21..24, y = 31..34. Required pairs (a.re, b.re, src, tw): (1,3,0,0), (2,4,0,1), (11,13,1,0), (12,14,1,1), (21,23,0,0), (22,24,0,1). Each appears one cycle after its completing input, with im = -re.
- Same stream with in_valid deasserted for 3 cycles after the 3rd sample: identical pair sequence. out_valid stays 0 during the gap and the outputs hold.
- Reset asserted for 1 cycle after the 5th sample, then restart with the frame-1 stimulus: no out_valid for the first 2 inputs. The first pair is (1,3) and no pre-reset data appears.
- Full-scale Q8.8 values: x.re = 0x7FFF, 0x8000, 256, -256 pass through bit-exact, confirming no sign/width alteration.
- D=4 and D=1 instances, 3 back-to-back frames of ramp data: every pair satisfies b = a + D within its stream. tw_idx cycles 0..D-1 and out_src alternates every D pairs.
- rst and in_valid high in the same cycle: the input is ignored, and cnt = 0 and primed = 0 afterwards.
